// File: rtl/game_pkg.sv
// Shared definitions for the switch game: FSM state encodings, default
// phase lengths and datapath widths.
package game_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ROUND = 2'd1;
  localparam logic [1:0] S_BREAK = 2'd2;
  localparam logic [1:0] S_OVER  = 2'd3;

  localparam int ROUND_TIME_DEF = 15;
  localparam int BREAK_TIME_DEF = 5;

  localparam int SCORE_W = 10;
  localparam int COUNT_W = 6;

endpackage

// File: rtl/score_keeper.sv
// Score accumulator and level multiplier. A pass adds points at the
// multiplier currently in force, then the multiplier is refreshed from the
// post-increment passed count supplied by the sequencer.
module score_keeper
  import game_pkg::*;
#(
  parameter int ROUNDS_PER_LEVEL = 5,
  parameter int POINTS_PER_ROUND = 2,
  parameter int MAX_MULT_LOG2    = 3,
  parameter int SCORE_MAX        = 999,
  parameter int PASS_W           = 7
) (
  input  logic               clk1Hz,
  input  logic               reset_btn,
  input  logic               clear_i,
  input  logic               pass_pulse_i,
  input  logic [PASS_W-1:0]  passed_i,
  output logic [SCORE_W-1:0] score_o,
  output logic [3:0]         multiplier_o
);

  localparam int EW = (MAX_MULT_LOG2 > 0) ? $clog2(MAX_MULT_LOG2 + 1) : 1;

  logic [SCORE_W-1:0] score_q, score_d;
  logic [3:0]         mult_q, mult_d;
  logic [SCORE_W:0]   sum;
  logic [PASS_W-1:0]  level;
  logic [EW-1:0]      expo;

  // Saturating add in one extra bit, and the capped level exponent.
  always_comb begin
    sum    = {1'b0, score_q} + (SCORE_W+1)'(POINTS_PER_ROUND) * (SCORE_W+1)'(mult_q);
    score_d = (sum > (SCORE_W+1)'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX) : sum[SCORE_W-1:0];
    level  = passed_i / PASS_W'(ROUNDS_PER_LEVEL);
    expo   = (level > PASS_W'(MAX_MULT_LOG2)) ? EW'(MAX_MULT_LOG2) : EW'(level);
    mult_d = 4'd1 << expo;
  end

  // Score and multiplier registers; clear wins over a pass (never both).
  always_ff @(posedge clk1Hz or posedge reset_btn) begin
    if (reset_btn) begin
      score_q <= '0;
      mult_q  <= 4'd1;
    end else if (clear_i) begin
      score_q <= '0;
      mult_q  <= 4'd1;
    end else if (pass_pulse_i) begin
      score_q <= score_d;
      mult_q  <= mult_d;
    end
  end

  assign score_o      = score_q;
  assign multiplier_o = mult_q;

endmodule

// File: rtl/round_controller.sv
// Game sequencer on the 1 Hz tick: round/break countdown, prompt requests,
// switch-check event judging and round bookkeeping. Scoring is delegated to
// score_keeper.
module round_controller
  import game_pkg::*;
#(
  parameter int ROUND_TIME       = ROUND_TIME_DEF,
  parameter int BREAK_TIME       = BREAK_TIME_DEF,
  parameter int ROUNDS_PER_LEVEL = 5,
  parameter int POINTS_PER_ROUND = 2,
  parameter int MAX_MULT_LOG2    = 3,
  parameter int SCORE_MAX        = 999
) (
  input  logic               clk1Hz,
  input  logic               reset_btn,
  input  logic               start,
  input  logic               check_toggle,
  input  logic               is_correct,
  output logic [COUNT_W-1:0] count,
  output logic               in_round,
  output logic               prompt_toggle,
  output logic [6:0]         round_num,
  output logic [3:0]         multiplier,
  output logic [SCORE_W-1:0] score,
  output logic               game_over
);

  localparam int PASS_W = 7;

  logic [1:0]         state_q, state_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               prompt_q, prompt_d;
  logic [6:0]         round_q, round_d;
  logic [PASS_W-1:0]  passed_q, passed_d;
  logic               chk_q;
  logic               in_round_q, game_over_q;
  logic               evt, clear, pass_pulse;

  // Any level change on the checker's flag since last tick is one event;
  // a double toggle inside one tick is invisible by construction.
  assign evt = check_toggle ^ chk_q;

  // Next-state logic; events take priority over the ROUND timeout.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    prompt_d   = prompt_q;
    round_d    = round_q;
    passed_d   = passed_q;
    clear      = 1'b0;
    pass_pulse = 1'b0;
    case (state_q)
      S_IDLE, S_OVER: begin
        if (start) begin
          clear    = 1'b1;
          passed_d = '0;
          round_d  = 7'd1;
          count_d  = COUNT_W'(ROUND_TIME);
          prompt_d = ~prompt_q;
          state_d  = S_ROUND;
        end
      end
      S_ROUND: begin
        if (evt && is_correct) begin
          pass_pulse = 1'b1;
          passed_d   = (&passed_q) ? passed_q : passed_q + 1'b1;
          count_d    = COUNT_W'(BREAK_TIME);
          state_d    = S_BREAK;
        end else if (evt) begin
          state_d = S_OVER;
        end else if (count_q == '0) begin
          state_d = S_OVER;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
      S_BREAK: begin
        if (count_q == '0) begin
          count_d  = COUNT_W'(ROUND_TIME);
          round_d  = (round_q >= 7'd99) ? 7'd99 : round_q + 7'd1;
          prompt_d = ~prompt_q;
          state_d  = S_ROUND;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer registers, with phase flags registered alongside the state.
  always_ff @(posedge clk1Hz or posedge reset_btn) begin
    if (reset_btn) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      prompt_q    <= 1'b0;
      round_q     <= '0;
      passed_q    <= '0;
      chk_q       <= 1'b0;
      in_round_q  <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      prompt_q    <= prompt_d;
      round_q     <= round_d;
      passed_q    <= passed_d;
      chk_q       <= check_toggle;
      in_round_q  <= (state_d == S_ROUND);
      game_over_q <= (state_d == S_OVER);
    end
  end

  score_keeper #(
    .ROUNDS_PER_LEVEL(ROUNDS_PER_LEVEL),
    .POINTS_PER_ROUND(POINTS_PER_ROUND),
    .MAX_MULT_LOG2   (MAX_MULT_LOG2),
    .SCORE_MAX       (SCORE_MAX),
    .PASS_W          (PASS_W)
  ) u_score (
    .clk1Hz      (clk1Hz),
    .reset_btn   (reset_btn),
    .clear_i     (clear),
    .pass_pulse_i(pass_pulse),
    .passed_i    (passed_d),
    .score_o     (score),
    .multiplier_o(multiplier)
  );

  assign count         = count_q;
  assign in_round      = in_round_q;
  assign prompt_toggle = prompt_q;
  assign round_num     = round_q;
  assign game_over     = game_over_q;

endmodule

// File: doc/round_controller.md
# round_controller

Game sequencer for the switch game. Runs on the 1 Hz tick and owns the round/break countdown. It requests new LED prompts from the prompt generator and judges switch-check events from the arrangement checker. It also accumulates the score with the level multiplier. It drives the countdown value to the HEX4/HEX5 display path and the score to the remaining HEX digits.

## Interface
- ROUND_TIME, 15: seconds allowed per round.
- BREAK_TIME, 5: seconds between rounds.
- ROUNDS_PER_LEVEL, 5: passed rounds per multiplier doubling.
- POINTS_PER_ROUND, 2: base points per passed round.
- MAX_MULT_LOG2, 3: multiplier cap exponent (max ×8).
- SCORE_MAX, 999: saturation value of score.

Ports:
- Reset is reset_btn, asynchronous, active-high; clock is clk1Hz.
- clk1Hz  in  1  game tick.
- reset_btn  in  1  asynchronous active-high reset.
- start  in  1  start/restart request, level, already synchronised and inverted from KEY[1].
- check_toggle  in  1  toggles once per switch change (checker's event flag).
- is_correct  in  1  checker verdict for the latest event.
- count  out  6  seconds remaining in current phase.
- in_round  out  1  high in ROUND.
- prompt_toggle  out  1  toggles once per new-prompt request (drives chooseFlag).
- round_num  out  7  current round number, saturates at 99.
- multiplier  out  4  current point multiplier (1, 2, 4, 8).
- score  out  10  accumulated score.
- game_over  out  1  high in OVER.

## Operation
- States are IDLE, ROUND, BREAK and OVER. State is 2-bit and encoded in the shared package.
- The event detector samples check_toggle every tick into chk_q. An event is check_toggle != chk_q, and chk_q updates on every tick in every state.
- IDLE or OVER with start=1:
  - Clear score to 0, passed to 0, multiplier to 1.
  - Set round_num=1 and count=ROUND_TIME.
  - Toggle prompt_toggle and go to ROUND.
  - Events in IDLE or OVER are ignored.
- ROUND, per tick, first match wins:
  1. Event with is_correct=1 is a pass. Do score += POINTS_PER_ROUND×multiplier, saturating at SCORE_MAX. Increment passed. Set count=BREAK_TIME and go to BREAK.
  2. Event with is_correct=0 is a fail. Go to OVER and freeze count.
  3. count==0 is a timeout. Go to OVER.
  4. Otherwise count -= 1.
- BREAK, per tick: events are ignored.
  - If count==0: count=ROUND_TIME, round_num+=1, toggle prompt_toggle, go to ROUND.
  - Else count -= 1.
- The multiplier is 1 << min(passed / ROUNDS_PER_LEVEL, MAX_MULT_LOG2). It is recomputed from the post-increment passed value, so the 5th pass still scores ×1 and the 6th scores ×2.
- start is ignored in ROUND and BREAK.
- Known limitation: two switch toggles within one tick cancel and produce no event. This is accepted.

## Timing
- All outputs are registered and update on the rising edge of clk1Hz.
- Reset values: state IDLE, count 0, in_round 0, prompt_toggle 0, round_num 0, multiplier 1, score 0, game_over 0, chk_q 0.
- Reset mid-round or mid-break aborts immediately with no score update. prompt_toggle returns to 0, so the prompt generator sees one extra toggle. That is acceptable.
- Event latency is one tick from the check_toggle change to the state change.
- Entry to ROUND shows count=ROUND_TIME, then 14..0, then the timeout tick. The round lasts ROUND_TIME+1 ticks, and the display shows 0 for one full tick before OVER.
- BREAK likewise shows 5..0, which is BREAK_TIME+1 ticks.
- An event on the same tick that count reads 0 in ROUND is evaluated as an event; events take priority over timeout.
- Score arithmetic uses 11-bit intermediates, with the saturation compare before the writeback.

## Structure
- game_pkg holds:
  - state encodings (S_IDLE, S_ROUND, S_BREAK, S_OVER);
  - default ROUND_TIME/BREAK_TIME constants;
  - SCORE_W=10 and COUNT_W=6.
- One sub-module, score_keeper, takes passed/pass_pulse/clear and returns score and multiplier. It isolates the saturation and multiplier arithmetic.
- The FSM, countdown and event detector live in round_controller itself.

## Test plan
- Reset then start=1 for one tick → ROUND, count=15, round_num=1, prompt_toggle=1. After 3 ticks with no event, count=12.
- In ROUND, toggle check_toggle with is_correct=1 → next edge BREAK, count=5, score=2. After 6 ticks: ROUND, round_num=2, prompt_toggle toggled, count=15.
- Pass 6 consecutive rounds → score 2,4,6,8,10,14 and multiplier 1,1,1,1,2,2. At 20 passes, multiplier=8 and stays 8 after further passes.
- No event for 16 ticks in ROUND → game_over=1, score held. start=1 then restarts with score=0 and round_num=1.
- Event with is_correct=0 → OVER next edge, count frozen at its current value. Event in BREAK → ignored, score unchanged.
- Assert reset_btn mid-BREAK between clock edges → all outputs at reset values immediately. Force score to 990 with multiplier 8 and pass → score=999.
